half_adder_df: RTL and testbench
================================

Name: half_adder_df

Overview:
- Bit-parallel half adder in dataflow style: sum = a XOR b, carry = a AND b.
- Combinational outputs are always valid, with zero latency.
- A registered copy adds a valid flag and a saturating carry-event counter for pipelined consumers.
- Sits at the leaf of arithmetic datapaths; used standalone or as the building block of ripple and carry-save adders.

Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes (bitwise, no inter-lane carry).
- CNT_W, 16, width of the carry-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a/b for the registered path and the counter.
- clr_cnt  input  1  synchronous clear of carry_cnt.
- s  output  WIDTH  combinational sum, a ^ b.
- c  output  WIDTH  combinational carry, a & b.
- s_q  output  WIDTH  registered sum.
- c_q  output  WIDTH  registered carry.
- out_valid  output  1  registered in_valid.
- carry_cnt  output  CNT_W  saturating count of valid cycles with any carry.

Behaviour:
- Clocking: one clock domain (clk); reset asynchronous, active-low (rst_n).
- Combinational path:
  - s[i] = a[i] ^ b[i]; c[i] = a[i] & b[i] for every lane.
  - Pure continuous assignment; no dependence on clk, rst_n or in_valid.
  - Must be correct immediately after any input change.
- Truth table per lane (a,b -> s,c): 00->00, 01->10, 10->10, 11->01.
- Reset (rst_n low, asynchronous): s_q=0, c_q=0, out_valid=0, carry_cnt=0. Combinational s/c are unaffected by reset.
- Registered path, 1-cycle latency:
  - On a rising clk with in_valid=1: s_q<=s, c_q<=c.
  - With in_valid=0: s_q/c_q hold their values.
  - out_valid<=in_valid every cycle.
- Counter:
  - On a rising clk, if clr_cnt=1, carry_cnt<=0; clr_cnt has priority over increment.
  - Else if in_valid=1 and |c, carry_cnt<=carry_cnt+1.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset mid-operation: all registers clear immediately. The first valid cycle after rst_n deasserts is captured normally.
- No X propagation: registers are fully reset; in_valid=0 does not require a/b to be known.

Optional Feature:
- Macro HALF_ADDER_SELFCHK_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - Each cycle out_valid=1, for each lane, checks s_q + 2*c_q == a_reg + b_reg. a_reg/b_reg are internal copies of a/b captured alongside s_q/c_q.
  - err is sticky until reset.
- When undefined: no err port, no extra registers, identical behaviour otherwise.

Decomposition:
- Shared package half_adder_pkg holds:
  - the default WIDTH and CNT_W constants;
  - the saturation limit as a function of CNT_W;
  - a typedef for the lane vector.
- One natural sub-module: half_adder_lane (single-bit s/c dataflow), generated WIDTH times.
- Registers and the counter stay in the top module.

Test Plan:
- Combinational sweep, WIDTH=1, no clock dependence. Apply (a,b) = 00, 01, 10, 11, 00, 01, 10, 11 at 10 ns steps -> (s,c) = 00, 10, 10, 01, 00, 10, 10, 01, each settled within the step.
- Reset: assert rst_n=0 mid-run with s_q=0, c_q=1, carry_cnt=3 -> all registered outputs 0 without a clock edge. Combinational s/c still track a/b.
- Registered latency: in_valid=1, a=1, b=1 at edge N -> s_q=0, c_q=1, out_valid=1 after edge N. Then in_valid=0, a=0, b=1 -> s_q/c_q hold 0/1, out_valid=0.
- Counter: 4 valid cycles with (a,b) = 11, 01, 11, 10 -> carry_cnt=2. Asserting clr_cnt together with a valid 11 cycle -> carry_cnt=0.
- Saturation: CNT_W=2, 5 valid 11 cycles -> carry_cnt stays at 3.
- Multi-lane: WIDTH=4, a=4'b1100, b=4'b1010 -> s=4'b0110, c=4'b1000. With HALF_ADDER_SELFCHK_EN defined -> err remains 0.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared definitions for the half_adder_df block: default lane count,
// default carry-event counter width, counter saturation limit and the
// lane vector type.
package half_adder_pkg;

    localparam int HA_WIDTH_DEF = 1;
    localparam int HA_CNT_W_DEF = 16;

    typedef logic [HA_WIDTH_DEF-1:0] lane_vec_t;

    // Largest value a cnt_w-bit counter can hold (2^cnt_w - 1).
    function automatic logic [63:0] cnt_sat_limit(input int cnt_w);
        cnt_sat_limit = (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage : half_adder_pkg

// File: rtl/half_adder_lane.sv
// Single-bit half adder in dataflow form: s = a ^ b, c = a & b.
module half_adder_lane (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder_lane

// File: rtl/half_adder_df.sv
// Bit-parallel half adder. WIDTH independent lanes, no carry between lanes.
// Combinational s/c are pure dataflow and ignore clk/rst_n/in_valid.
// A registered copy (s_q/c_q/out_valid) and a saturating counter of valid
// cycles carrying in any lane serve pipelined consumers.
// Optional build macro HALF_ADDER_SELFCHK_EN adds a sticky err output that
// re-checks the registered result against captured copies of a/b.
module half_adder_df
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH_DEF,
    parameter int CNT_W = HA_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s_q,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
`ifdef HALF_ADDER_SELFCHK_EN
    output logic [CNT_W-1:0] carry_cnt,
    output logic             err
`else
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_limit(CNT_W));

    logic [WIDTH-1:0] s_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] s_q_r;
    logic [WIDTH-1:0] c_q_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] carry_cnt_r;
    logic             carry_hit_s;
    logic             cnt_at_max_s;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        half_adder_lane u_lane (
            .a (a[gi]),
            .b (b[gi]),
            .s (s_s[gi]),
            .c (c_s[gi])
        );
    end

    assign s = s_s;
    assign c = c_s;

    // A carry event is a qualified cycle where at least one lane carries.
    always_comb begin
        carry_hit_s  = in_valid & (|c_s);
        cnt_at_max_s = (carry_cnt_r == CNT_MAX);
    end

    // Capture the sum/carry on qualified cycles; out_valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q_r       <= {WIDTH{1'b0}};
            c_q_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                s_q_r <= s_s;
                c_q_r <= c_s;
            end else begin
                s_q_r <= s_q_r;
                c_q_r <= c_q_r;
            end
        end
    end

    // Saturating carry-event counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            carry_cnt_r <= {CNT_W{1'b0}};
        end else if (carry_hit_s && !cnt_at_max_s) begin
            carry_cnt_r <= carry_cnt_r + CNT_W'(1);
        end else begin
            carry_cnt_r <= carry_cnt_r;
        end
    end

    assign s_q       = s_q_r;
    assign c_q       = c_q_r;
    assign out_valid = out_valid_r;
    assign carry_cnt = carry_cnt_r;

`ifdef HALF_ADDER_SELFCHK_EN
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             chk_bad_s;
    logic             err_r;

    // Keep the operands that produced s_q/c_q so the result can be re-derived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
        end else if (in_valid) begin
            a_r <= a;
            b_r <= b;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    // Per lane, the registered pair must encode a_r + b_r as {c_q, s_q}.
    always_comb begin
        chk_bad_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (({1'b0, s_q_r[i]} + {c_q_r[i], 1'b0}) !=
                ({1'b0, a_r[i]} + {1'b0, b_r[i]})) begin
                chk_bad_s = 1'b1;
            end else begin
                chk_bad_s = chk_bad_s;
            end
        end
    end

    // Sticky error flag, only evaluated while the registered data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (out_valid_r && chk_bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`endif

endmodule : half_adder_df

// File: tb/tb_half_adder_df.sv
// Directed self-checking bench for half_adder_df: one default instance
// (WIDTH=1, CNT_W=16) and one narrow-counter multi-lane instance
// (WIDTH=4, CNT_W=2).
module tb_half_adder_df;

    logic        clk;
    logic        rst_n;

    logic        a1, b1, iv1, clr1;
    logic        s1, c1, sq1, cq1, ov1;
    logic [15:0] cnt1;

    logic [3:0]  a4, b4;
    logic        iv4, clr4;
    logic [3:0]  s4, c4, sq4, cq4;
    logic        ov4;
    logic [1:0]  cnt4;

`ifdef HALF_ADDER_SELFCHK_EN
    logic        err1, err4;
`endif

    int tests_run;
    int tests_failed;

    // {a, b, s, c}
    logic [3:0] sweep_v [4];

    half_adder_df #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (iv1),
        .clr_cnt   (clr1),
        .s         (s1),
        .c         (c1),
        .s_q       (sq1),
        .c_q       (cq1),
        .out_valid (ov1),
`ifdef HALF_ADDER_SELFCHK_EN
        .carry_cnt (cnt1),
        .err       (err1)
`else
        .carry_cnt (cnt1)
`endif
    );

    half_adder_df #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .in_valid  (iv4),
        .clr_cnt   (clr4),
        .s         (s4),
        .c         (c4),
        .s_q       (sq4),
        .c_q       (cq4),
        .out_valid (ov4),
`ifdef HALF_ADDER_SELFCHK_EN
        .carry_cnt (cnt4),
        .err       (err4)
`else
        .carry_cnt (cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        tests_run    = 0;
        tests_failed = 0;
        sweep_v[0] = 4'b0000;
        sweep_v[1] = 4'b0110;
        sweep_v[2] = 4'b1010;
        sweep_v[3] = 4'b1101;

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0; clr1 = 1'b0;
        a4 = 4'b0000; b4 = 4'b0000; iv4 = 1'b0; clr4 = 1'b0;
        #3;
        check_eq("rst_sq1",  {31'd0, sq1}, 32'd0);
        check_eq("rst_cq1",  {31'd0, cq1}, 32'd0);
        check_eq("rst_ov1",  {31'd0, ov1}, 32'd0);
        check_eq("rst_cnt1", {16'd0, cnt1}, 32'd0);
        check_eq("rst_cnt4", {30'd0, cnt4}, 32'd0);

        // Combinational sweep, independent of clock and reset
        for (int k = 0; k < 8; k++) begin
            v  = sweep_v[k % 4];
            a1 = v[3];
            b1 = v[2];
            #1;
            check_eq($sformatf("comb_s_%0d", k), {31'd0, s1}, {31'd0, v[1]});
            check_eq($sformatf("comb_c_%0d", k), {31'd0, c1}, {31'd0, v[0]});
            #9;
        end

        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check_eq("comb_s4", {28'd0, s4}, 32'h6);
        check_eq("comb_c4", {28'd0, c4}, 32'h8);

        @(negedge clk);
        rst_n = 1'b1;

        // Registered latency and hold
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        tick();
        check_eq("lat_sq",  {31'd0, sq1}, 32'd0);
        check_eq("lat_cq",  {31'd0, cq1}, 32'd1);
        check_eq("lat_ov",  {31'd0, ov1}, 32'd1);
        check_eq("lat_cnt", {16'd0, cnt1}, 32'd1);
        a1 = 1'b0; b1 = 1'b1; iv1 = 1'b0;
        tick();
        check_eq("hold_sq", {31'd0, sq1}, 32'd0);
        check_eq("hold_cq", {31'd0, cq1}, 32'd1);
        check_eq("hold_ov", {31'd0, ov1}, 32'd0);
        check_eq("hold_s",  {31'd0, s1},  32'd1);
        check_eq("hold_cnt", {16'd0, cnt1}, 32'd1);

        // Counter: clear, then 11,01,11,10 -> 2
        clr1 = 1'b1;
        tick();
        check_eq("clr_cnt", {16'd0, cnt1}, 32'd0);
        clr1 = 1'b0;
        iv1 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; tick();
        a1 = 1'b0; b1 = 1'b1; tick();
        a1 = 1'b1; b1 = 1'b1; tick();
        a1 = 1'b1; b1 = 1'b0; tick();
        check_eq("cnt_4vec", {16'd0, cnt1}, 32'd2);
        check_eq("cnt_sq",   {31'd0, sq1}, 32'd1);
        check_eq("cnt_cq",   {31'd0, cq1}, 32'd0);

        // Clear has priority over a carrying valid cycle
        clr1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        check_eq("clr_prio", {16'd0, cnt1}, 32'd0);
        check_eq("clr_cq",   {31'd0, cq1}, 32'd1);
        clr1 = 1'b0;
        tick(); tick(); tick();
        check_eq("pre_rst_cnt", {16'd0, cnt1}, 32'd3);

        // Asynchronous reset mid-cycle
        iv1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sq",  {31'd0, sq1}, 32'd0);
        check_eq("arst_cq",  {31'd0, cq1}, 32'd0);
        check_eq("arst_ov",  {31'd0, ov1}, 32'd0);
        check_eq("arst_cnt", {16'd0, cnt1}, 32'd0);
        a1 = 1'b1; b1 = 1'b0;
        #1;
        check_eq("arst_s", {31'd0, s1}, 32'd1);
        check_eq("arst_c", {31'd0, c1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        tick();
        check_eq("post_rst_cq",  {31'd0, cq1}, 32'd1);
        check_eq("post_rst_ov",  {31'd0, ov1}, 32'd1);
        check_eq("post_rst_cnt", {16'd0, cnt1}, 32'd1);

        // Unknown operands while not valid must not disturb state
        a1 = 1'bx; b1 = 1'bx; iv1 = 1'b0;
        tick();
        check_eq("xin_sq",  {31'd0, sq1}, 32'd0);
        check_eq("xin_cq",  {31'd0, cq1}, 32'd1);
        check_eq("xin_cnt", {16'd0, cnt1}, 32'd1);
        a1 = 1'b0; b1 = 1'b0;

        // Multi-lane and 2-bit saturation
        a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1;
        tick();
        check_eq("sat_c1", {30'd0, cnt4}, 32'd1);
        check_eq("ml_sq4", {28'd0, sq4}, 32'h6);
        check_eq("ml_cq4", {28'd0, cq4}, 32'h8);
        check_eq("ml_ov4", {31'd0, ov4}, 32'd1);
        tick();
        tick();
        check_eq("sat_c3", {30'd0, cnt4}, 32'd3);
        tick();
        check_eq("sat_c4", {30'd0, cnt4}, 32'd3);
        tick();
        check_eq("sat_c5", {30'd0, cnt4}, 32'd3);
        a4 = 4'b1111; b4 = 4'b0101;
        #1;
        check_eq("ml2_s4", {28'd0, s4}, 32'hA);
        check_eq("ml2_c4", {28'd0, c4}, 32'h5);
        tick();
        check_eq("ml2_sq4", {28'd0, sq4}, 32'hA);
        check_eq("ml2_cq4", {28'd0, cq4}, 32'h5);
        iv4 = 1'b0;
        tick();

`ifdef HALF_ADDER_SELFCHK_EN
        check_eq("err1", {31'd0, err1}, 32'd0);
        check_eq("err4", {31'd0, err4}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_half_adder_df
